// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU core and its program sequencer.
// Holds the opcode encodings, the sequencer state encoding and the value
// returned for divide/modulo by zero.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  localparam logic [7:0] DIVZ_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU.
// Ports:
//   op     [3:0] in  : opcode (see alu_pkg)
//   x      [3:0] in  : first operand
//   y      [3:0] in  : second operand
//   result [7:0] out : 8-bit result
//   divz         out : divide or modulo by zero (result forced to DIVZ_RESULT)
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] result,
  output logic       divz
);

  logic [7:0] xz, yz, xs, ys;

  assign xz = {4'h0, x};
  assign yz = {4'h0, y};
  // Subtraction treats both operands as 4-bit two's complement.
  assign xs = {{4{x[3]}}, x};
  assign ys = {{4{y[3]}}, y};

  always_comb begin
    result = 8'h00;
    divz   = 1'b0;
    case (op)
      OP_ADD:  result = xz + yz;
      OP_SUB:  result = xs - ys;
      OP_MUL:  result = xz * yz;
      OP_DIV: begin
        if (y == 4'h0) begin
          result = DIVZ_RESULT;
          divz   = 1'b1;
        end else begin
          result = xz / yz;
        end
      end
      OP_AND:  result = {4'h0, x & y};
      OP_OR:   result = {4'h0, x | y};
      OP_XOR:  result = {4'h0, x ^ y};
      OP_NAND: result = {4'h0, ~(x & y)};
      OP_NOR:  result = {4'h0, ~(x | y)};
      OP_NOT:  result = ~{y, x};
      OP_MOD: begin
        if (y == 4'h0) begin
          result = DIVZ_RESULT;
          divz   = 1'b1;
        end else begin
          result = xz % yz;
        end
      end
      OP_SHL:  result = xz << y;
      OP_SHR:  result = xz >> y;
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Program sequencer for the 4-bit ALU core. Buffers {opcode, operand} steps
// and runs them back-to-back on an 8-bit accumulator, chaining acc[3:0] into
// each following step as x.
// Ports:
//   clk, rst_n (sync, active-low), ena (clock enable, freezes all state)
//   load_valid/load_op/load_operand : append one step (IDLE only)
//   clear : empty buffer and clear ovf (IDLE only, wins over load)
//   start/init : run the buffer from acc = {4'h0, init} (IDLE, count > 0)
//   busy, done : decoded from state
//   err : sticky divide/modulo by zero, cleared on accepted start
//   ovf : sticky load-while-full, cleared by clear
//   acc : accumulator, count : buffered steps
//
// state  | meaning
// S_IDLE | accept load/clear/start
// S_RUN  | apply step pc each enabled edge
// S_DONE | one-cycle done pulse, then back to IDLE
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       load_valid,
  input  logic [3:0]                 load_op,
  input  logic [3:0]                 load_operand,
  input  logic                       clear,
  input  logic                       start,
  input  logic [3:0]                 init,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       ovf,
  output logic [7:0]                 acc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      buf_op_q  [DEPTH];
  logic [3:0]      buf_op_d  [DEPTH];
  logic [3:0]      buf_opd_q [DEPTH];
  logic [3:0]      buf_opd_d [DEPTH];

  logic [7:0]      alu_result;
  logic            alu_divz;
  logic            last_step;

  alu_core u_alu (
    .op     (buf_op_q[pc_q]),
    .x      (acc_q[3:0]),
    .y      (buf_opd_q[pc_q]),
    .result (alu_result),
    .divz   (alu_divz)
  );

  assign last_step = ({1'b0, pc_q} == (count_q - CW'(1)));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    wptr_d    = wptr_q;
    pc_d      = pc_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    buf_op_d  = buf_op_q;
    buf_opd_d = buf_opd_q;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
          wptr_d  = '0;
          ovf_d   = 1'b0;
        end else if (load_valid) begin
          if (count_q < FULL) begin
            buf_op_d[wptr_q]  = load_op;
            buf_opd_d[wptr_q] = load_operand;
            wptr_d            = wptr_q + AW'(1);
            count_d           = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (start && (count_q != '0)) begin
          acc_d   = {4'h0, init};
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = alu_result;
        if (alu_divz) err_d = 1'b1;
        pc_d = pc_q + AW'(1);
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Buffer contents need no reset; count gates what is ever read.
  always_ff @(posedge clk) begin
    if (ena) begin
      buf_op_q  <= buf_op_d;
      buf_opd_q <= buf_opd_d;
    end
  end

  assign busy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign err   = err_q;
  assign ovf   = ovf_q;
  assign acc   = acc_q;
  assign count = count_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Program sequencer for the 4-bit ALU core. It holds a small buffer of {opcode, operand} steps and runs them back-to-back on an 8-bit accumulator, one step per enabled clock. The low nibble of each result is chained into the next step as `x`. It sits between the tile's input pins and the ALU datapath and replaces direct per-cycle opcode driving from the pins.

## Interface
Parameters:
- `DEPTH`, default 4: program buffer entries (power of two, 2..16).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `ena`, in, 1: clock enable. When low, all state is frozen (reset still acts).
- `load_valid`, in, 1: write one step into the buffer this cycle.
- `load_op`, in, 4: step opcode.
- `load_operand`, in, 4: step operand, used as `y`.
- `clear`, in, 1: empty the buffer. Honoured only in IDLE.
- `start`, in, 1: begin execution. Honoured only in IDLE with count > 0.
- `init`, in, 4: initial accumulator value, captured on accepted start.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle pulse, high in DONE.
- `err`, out, 1: sticky flag for divide/modulo by zero; cleared on the next accepted start.
- `ovf`, out, 1: sticky flag for a load while full; cleared by `clear` or reset.
- `acc`, out, 8: accumulator/result.
- `count`, out, $clog2(DEPTH)+1: number of buffered steps.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `load_valid` with count < DEPTH: write the step at `wptr`, then increment `wptr` and `count`.
  - `load_valid` with count == DEPTH: write nothing, set `ovf`.
  - `clear`: set count, `wptr` and `ovf` to 0.
  - If `clear` and `load_valid` arrive together, `clear` wins.
  - `start` with count > 0: `acc <= {4'h0, init}`, `pc <= 0`, `err <= 0`, go to RUN.
  - `start` with count == 0 is ignored.
- **RUN**
  - Each enabled edge: `acc <= alu(op[pc], acc[3:0], operand[pc])`, `pc <= pc+1`.
  - After the step at `pc == count-1`, go to DONE.
  - `load_valid`, `clear` and `start` are ignored (no `ovf` effect).
- **DONE**: `done = 1` for one cycle, then go to IDLE. The buffer is retained, so a new `start` re-runs it.
- **ALU op encoding** (x = `acc[3:0]`, y = operand; result 8 bits):
  - 0: x+y.
  - 1: x−y, with both sign-extended as 4-bit signed.
  - 2: x*y.
  - 3: x/y.
  - 4: AND; 5: OR; 6: XOR; 7: NAND; 8: NOR, all 4-bit, zero-extended.
  - 9: ~{y,x}.
  - 10: x%y.
  - 11: x<<y, 8-bit result.
  - 12: x>>y.
  - 13–15: result 0.
- **Divide/modulo by zero** (op 3 or 10 with y == 0): result 8'hFF, `err` set. Execution continues.
- **Reset**, at any state including mid-RUN: IDLE; `acc`, `count`, `wptr`, `pc`, `err`, `ovf`, `done`, `busy` all 0. Buffer contents are don't-care.

## Timing
- `start` sampled at edge E0; `busy` is high from E0+.
- Step k is applied at edge E(k+1).
- `done` is high in the cycle after edge E(count); final `acc` is visible in that same cycle.
- `acc` holds until the next accepted start or reset.
- Start-to-done latency is count+1 enabled edges. Back-to-back start is possible at the edge ending DONE+1 (the first IDLE cycle).
- `ena` low stretches every phase: no state advance and no `done` change. `done` stays high for the whole DONE cycle until the next enabled edge.
- All outputs are registered, except `busy`/`done`, which are decoded from the state register.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams: `OP_ADD`..`OP_SHR`.
  - State encoding: `S_IDLE`, `S_RUN`, `S_DONE`.
  - `DIVZ_RESULT` = 8'hFF.
- Sub-module `alu_core`: purely combinational (op[3:0], x[3:0], y[3:0] → result[7:0], divz). It is instantiated once and is also reusable by the pin-level ALU top.
- The buffer is a register array indexed by `wptr`/`pc`; no RAM macro.

## Test plan
- Load {add,3}, {mul,2}; init 5; start → `acc` 8'h08 after step 0, 8'h10 at `done`, `done` high exactly at cycle E0+3.
- Load {sub,5}; init 3 → `acc` 8'hFE. Then init 8, {sub,1} → 8'hF7 (−8−1).
- Load {div,0}, {add,1}; init 7 → `err`=1; `acc` 8'hFF after step 0, then 8'h10 (F+1); `err` stays high after `done`.
- Fill 4 steps, load a 5th → `ovf`=1, count=4. Then `clear` together with `load_valid` → count=0, `ovf`=0.
- Start with count=0 → `busy` stays 0. During RUN, pulse `load_valid` and `start` → count unchanged, run unaffected.
- Assert `rst_n`=0 mid-RUN at step 1 → next cycle IDLE, `acc`=0, count=0. Also hold `ena`=0 for 3 cycles mid-RUN → `acc` and `pc` frozen, `done` delayed by exactly 3 cycles.
